// File: rtl/apb_regbank_slave.sv
// APB3 completer: word-addressed register bank with a read-only ID at index 0,
// programmable wait states, error response and a saturating write counter.
// Optional APB4 byte strobes are enabled by defining APB_REGBANK_PSTRB_EN.
module apb_regbank_slave #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                NUM_REGS    = 16,
    parameter int                WAIT_STATES = 1,
    parameter logic [DATA_W-1:0] ID_VALUE    = 32'hA5B0_0001
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
`ifdef APB_REGBANK_PSTRB_EN
    input  logic [DATA_W/8-1:0] PSTRB,
`endif
    output logic              PREADY,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PSLVERR,
    output logic [15:0]       wr_count
);

    localparam int                IDX_W      = $clog2(NUM_REGS);
    localparam int                NBYTES     = DATA_W / 8;
    localparam logic [0:0]        ST_IDLE    = 1'b0;
    localparam logic [0:0]        ST_ACCESS  = 1'b1;
    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(NUM_REGS * 4);

    logic [0:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [15:0]       wr_count_q, wr_count_d;

    logic [IDX_W-1:0]  idx_s;
    logic              err_s;
    logic              ready_s;
    logic [DATA_W-1:0] rd_data_s;
    logic [NBYTES-1:0] strb_s;

`ifdef APB_REGBANK_PSTRB_EN
    assign strb_s = PSTRB;
`else
    assign strb_s = '1;
`endif

    assign idx_s = PADDR[2 +: IDX_W];

    // Decode, completion strobe and read mux; PREADY is gated by rst_n so it stays low during reset
    always_comb begin
        err_s   = (PADDR[1:0] != 2'b00) || (PADDR >= ADDR_LIMIT) ||
                  (PWRITE && (idx_s == IDX_W'(0)));
        ready_s = rst_n && (state_q == ST_ACCESS) && (cnt_q == 4'd0) && PSEL && PENABLE;
        if (idx_s == IDX_W'(0)) begin
            rd_data_s = ID_VALUE;
        end else begin
            rd_data_s = regs_q[idx_s];
        end
    end

    // Transfer FSM, wait counter, register update and write counter next-state
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        regs_d     = regs_q;
        wr_count_d = wr_count_q;
        case (state_q)
            ST_IDLE: begin
                if (PSEL && !PENABLE) begin
                    state_d = ST_ACCESS;
                    cnt_d   = 4'(WAIT_STATES);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (!PSEL) begin
                    state_d = ST_IDLE;
                end else if (!PENABLE) begin
                    state_d = ST_ACCESS;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = ST_IDLE;
                    if (PWRITE && !err_s) begin
                        for (int b = 0; b < NBYTES; b++) begin
                            if (strb_s[b]) begin
                                regs_d[idx_s][8*b +: 8] = PWDATA[8*b +: 8];
                            end else begin
                                regs_d[idx_s][8*b +: 8] = regs_q[idx_s][8*b +: 8];
                            end
                        end
                        if (wr_count_q != 16'hFFFF) begin
                            wr_count_d = wr_count_q + 16'd1;
                        end else begin
                            wr_count_d = wr_count_q;
                        end
                    end else begin
                        wr_count_d = wr_count_q;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State registers with synchronous active-low reset; reset wins over any in-flight commit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            wr_count_q <= 16'd0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_count_q <= wr_count_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign PREADY   = ready_s;
    assign PSLVERR  = ready_s && err_s;
    assign PRDATA   = (ready_s && !err_s && !PWRITE) ? rd_data_s : '0;
    assign wr_count = wr_count_q;

endmodule
